// File: rtl/fpmul_cu.sv
// Sequencer for the single-precision multiplier datapath: issues every load/select/set/reset
// strobe from operand load through classification, exponent bias, normalize, round and range check.
module fpmul_cu (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       Op_NaN,
   input  logic       Op_Inf,
   input  logic       Op_Zero,
   input  logic       MPH23,
   input  logic       Round,
   input  logic       Carry,
   input  logic       UFlow,
   input  logic       OFlow,
   output logic       SA_LD,
   output logic       SB_LD,
   output logic       EA_LD,
   output logic       EB_LD,
   output logic       MA_LD,
   output logic       MB_LD,
   output logic       SP_LD,
   output logic       EP_RST,
   output logic       EP_SET,
   output logic       EP_LD,
   output logic [1:0] EP_SEL,
   output logic       MPH_RST,
   output logic       MPH_SET,
   output logic       MPH_LD,
   output logic [2:0] MPH_SEL,
   output logic       MPL_SEL,
   output logic       MPL_LD,
   output logic       UF_RST,
   output logic       UF_LD,
   output logic       OF_RST,
   output logic       OF_LD,
   output logic       P_RST,
   output logic       P_LD,
   output logic       busy,
   output logic       done,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_FLAG, S_CLASS, S_BIAS,
      S_NORM, S_ROUND, S_CHKEXP, S_WRITE, S_DONE
   } state_t;

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   assign state_o = state_q;

   // start is a level request sampled only in IDLE; while busy it is ignored, never queued.
   always_comb begin
      state_d = state_q;
      SA_LD   = 1'b0;  SB_LD   = 1'b0;  EA_LD  = 1'b0;  EB_LD  = 1'b0;
      MA_LD   = 1'b0;  MB_LD   = 1'b0;  SP_LD  = 1'b0;
      EP_RST  = 1'b0;  EP_SET  = 1'b0;  EP_LD  = 1'b0;  EP_SEL  = 2'b00;
      MPH_RST = 1'b0;  MPH_SET = 1'b0;  MPH_LD = 1'b0;  MPH_SEL = 3'b000;
      MPL_SEL = 1'b0;  MPL_LD  = 1'b0;
      UF_RST  = 1'b0;  UF_LD   = 1'b0;  OF_RST = 1'b0;  OF_LD  = 1'b0;
      P_RST   = 1'b0;  P_LD    = 1'b0;
      busy    = (state_q != S_IDLE);
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            SA_LD  = 1'b1;  SB_LD  = 1'b1;  EA_LD = 1'b1;
            EB_LD  = 1'b1;  MA_LD  = 1'b1;  MB_LD = 1'b1;
            UF_RST = 1'b1;  OF_RST = 1'b1;  P_RST = 1'b1;
            state_d = S_FLAG;
         end
         S_FLAG: begin
            state_d = S_CLASS;
         end
         S_CLASS: begin
            SP_LD = 1'b1;
            if (Op_NaN) begin
               EP_SET  = 1'b1;
               MPH_SET = 1'b1;
               state_d = S_WRITE;
            end else if (Op_Inf) begin
               EP_SET  = 1'b1;
               MPH_RST = 1'b1;
               state_d = S_WRITE;
            end else if (Op_Zero) begin
               EP_RST  = 1'b1;
               MPH_RST = 1'b1;
               state_d = S_WRITE;
            end else begin
               EP_LD   = 1'b1;
               MPH_LD  = 1'b1;
               MPL_LD  = 1'b1;
               state_d = S_BIAS;
            end
         end
         S_BIAS: begin
            EP_LD   = 1'b1;
            EP_SEL  = 2'b10;
            state_d = S_NORM;
         end
         S_NORM: begin
            // Product is in [1,4): either bump the exponent or shift left once, never both.
            if (MPH23) begin
               EP_LD  = 1'b1;
               EP_SEL = 2'b01;
            end else begin
               MPH_LD  = 1'b1;
               MPH_SEL = 3'b001;
               MPL_LD  = 1'b1;
               MPL_SEL = 1'b1;
            end
            state_d = S_ROUND;
         end
         S_ROUND: begin
            if (Round && Carry) begin
               MPH_LD  = 1'b1;
               MPH_SEL = 3'b100;
               EP_LD   = 1'b1;
               EP_SEL  = 2'b01;
            end else if (Round) begin
               MPH_LD  = 1'b1;
               MPH_SEL = 3'b010;
            end
            state_d = S_CHKEXP;
         end
         S_CHKEXP: begin
            if (UFlow) begin
               UF_LD   = 1'b1;
               EP_RST  = 1'b1;
               MPH_RST = 1'b1;
            end else if (OFlow) begin
               OF_LD   = 1'b1;
               EP_SET  = 1'b1;
               MPH_RST = 1'b1;
            end
            state_d = S_WRITE;
         end
         S_WRITE: begin
            P_LD    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fpmul_cu.sv
// Bench for fpmul_cu: a behavioural datapath closes the loop on the strobes, and an
// operation-level model predicts the control word of every cycle plus the final product.
module tb_fpmul_cu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start;
   logic       Op_NaN, Op_Inf, Op_Zero, MPH23, Round, Carry, UFlow, OFlow;
   logic       SA_LD, SB_LD, EA_LD, EB_LD, MA_LD, MB_LD, SP_LD;
   logic       EP_RST, EP_SET, EP_LD;
   logic [1:0] EP_SEL;
   logic       MPH_RST, MPH_SET, MPH_LD;
   logic [2:0] MPH_SEL;
   logic       MPL_SEL, MPL_LD, UF_RST, UF_LD, OF_RST, OF_LD, P_RST, P_LD, busy, done;
   logic [3:0] dbg_state;

   fpmul_cu dut (
      .clk(clk), .rst(rst), .start(start),
      .Op_NaN(Op_NaN), .Op_Inf(Op_Inf), .Op_Zero(Op_Zero), .MPH23(MPH23),
      .Round(Round), .Carry(Carry), .UFlow(UFlow), .OFlow(OFlow),
      .SA_LD(SA_LD), .SB_LD(SB_LD), .EA_LD(EA_LD), .EB_LD(EB_LD), .MA_LD(MA_LD), .MB_LD(MB_LD),
      .SP_LD(SP_LD), .EP_RST(EP_RST), .EP_SET(EP_SET), .EP_LD(EP_LD), .EP_SEL(EP_SEL),
      .MPH_RST(MPH_RST), .MPH_SET(MPH_SET), .MPH_LD(MPH_LD), .MPH_SEL(MPH_SEL),
      .MPL_SEL(MPL_SEL), .MPL_LD(MPL_LD), .UF_RST(UF_RST), .UF_LD(UF_LD),
      .OF_RST(OF_RST), .OF_LD(OF_LD), .P_RST(P_RST), .P_LD(P_LD),
      .busy(busy), .done(done), .state_o(dbg_state)
   );

   // Control word bit positions
   localparam logic [27:0] W_OPLD   = 28'h000003F, W_SPLD   = 28'h0000040;
   localparam logic [27:0] W_EPRST  = 28'h0000080, W_EPSET  = 28'h0000100;
   localparam logic [27:0] W_EPLD   = 28'h0000200, W_EP01   = 28'h0000400;
   localparam logic [27:0] W_EP10   = 28'h0000800, W_MPHRST = 28'h0001000;
   localparam logic [27:0] W_MPHSET = 28'h0002000, W_MPHLD  = 28'h0004000;
   localparam logic [27:0] W_MPH001 = 28'h0008000, W_MPH010 = 28'h0010000;
   localparam logic [27:0] W_MPH100 = 28'h0020000, W_MPLSEL = 28'h0040000;
   localparam logic [27:0] W_MPLLD  = 28'h0080000, W_UFRST  = 28'h0100000;
   localparam logic [27:0] W_UFLD   = 28'h0200000, W_OFRST  = 28'h0400000;
   localparam logic [27:0] W_OFLD   = 28'h0800000, W_PRST   = 28'h1000000;
   localparam logic [27:0] W_PLD    = 28'h2000000, W_BUSY   = 28'h4000000;
   localparam logic [27:0] W_DONE   = 28'h8000000;

   logic [27:0] cw;
   assign cw = {done, busy, P_LD, P_RST, OF_LD, OF_RST, UF_LD, UF_RST, MPL_LD, MPL_SEL,
                MPH_SEL, MPH_LD, MPH_SET, MPH_RST, EP_SEL, EP_LD, EP_SET, EP_RST, SP_LD,
                MB_LD, MA_LD, EB_LD, EA_LD, SB_LD, SA_LD};

   // ---------------- behavioural datapath ----------------
   logic [31:0] a_bus, b_bus;
   logic        sa, sb, sp, nan_q, inf_q, zero_q, uf_q, of_q;
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb, mph, mpl;
   logic [9:0]  ep;
   logic [31:0] p_q;
   logic [47:0] mp;

   assign mp = {24'h0, ma} * {24'h0, mb};

   always @(posedge clk) begin
      if (rst) begin
         sa <= 1'b0; sb <= 1'b0; sp <= 1'b0; ea <= '0; eb <= '0; ma <= '0; mb <= '0;
         ep <= '0; mph <= '0; mpl <= '0; uf_q <= 1'b0; of_q <= 1'b0; p_q <= '0;
         nan_q <= 1'b0; inf_q <= 1'b0; zero_q <= 1'b0;
      end else begin
         if (SA_LD) sa <= a_bus[31];
         if (SB_LD) sb <= b_bus[31];
         if (EA_LD) ea <= a_bus[30:23];
         if (EB_LD) eb <= b_bus[30:23];
         if (MA_LD) ma <= {1'b1, a_bus[22:0]};
         if (MB_LD) mb <= {1'b1, b_bus[22:0]};
         nan_q  <= (ea == 8'hFF && ma[22:0] != 0) || (eb == 8'hFF && mb[22:0] != 0) ||
                   (ea == 8'hFF && eb == 8'h00) || (ea == 8'h00 && eb == 8'hFF);
         inf_q  <= (ea == 8'hFF) || (eb == 8'hFF);
         zero_q <= (ea == 8'h00) || (eb == 8'h00);
         if (SP_LD) sp <= sa ^ sb;
         if (EP_RST)      ep <= '0;
         else if (EP_SET) ep <= 10'h0FF;
         else if (EP_LD)  ep <= EP_SEL[0] ? ep + 10'd1 :
                                EP_SEL[1] ? ep - 10'd127 : {2'b00, ea} + {2'b00, eb};
         if (MPH_RST)      mph <= '0;
         else if (MPH_SET) mph <= 24'hFFFFFF;
         else if (MPH_LD)  mph <= MPH_SEL[0] ? {mph[22:0], mpl[23]} :
                                  MPH_SEL[1] ? mph + 24'd1 :
                                  MPH_SEL[2] ? 24'h800000 : mp[47:24];
         if (MPL_LD) mpl <= MPL_SEL ? {mpl[22:0], 1'b0} : mp[23:0];
         if (UF_RST) uf_q <= 1'b0; else if (UF_LD) uf_q <= 1'b1;
         if (OF_RST) of_q <= 1'b0; else if (OF_LD) of_q <= 1'b1;
         if (P_RST) p_q <= '0; else if (P_LD) p_q <= {sp, ep[7:0], mph[22:0]};
      end
   end

   assign Op_NaN  = nan_q;
   assign Op_Inf  = inf_q;
   assign Op_Zero = zero_q;
   assign MPH23   = mph[23];
   assign Round   = mpl[23] & (mph[0] | (|mpl[22:0]));
   assign Carry   = &mph[22:0];
   assign UFlow   = ($signed(ep) <= 10'sd0);
   assign OFlow   = ($signed(ep) >= 10'sd255);

   // ---------------- scoreboard ----------------
   logic [27:0] exp_q[$];
   int          n_checks = 0, n_fail = 0, done_cnt = 0;
   logic        cmp_en = 1'b0, rc_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h (state %0d)", name, $time, act, exp,
                  dbg_state);
      end
   endtask

   // Operation-level model: the control word for every cycle from the IDLE cycle that
   // samples start up to DONE, plus the product and sticky flags the operation must leave.
   task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] p, output logic uf, output logic of);
      logic        an, ai, az, bn, bi, bz, sg, r, s, rnd, cy;
      logic [47:0] prod;
      logic [23:0] m;
      int          e;
      an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      az = (a[30:23] == 8'h00);
      bz = (b[30:23] == 8'h00);
      sg = a[31] ^ b[31];
      uf = 1'b0;
      of = 1'b0;
      exp_q.push_back('0);
      exp_q.push_back(W_BUSY | W_OPLD | W_UFRST | W_OFRST | W_PRST);
      exp_q.push_back(W_BUSY);
      if (an || bn || (ai && bz) || (az && bi)) begin
         exp_q.push_back(W_BUSY | W_SPLD | W_EPSET | W_MPHSET);
         p = {sg, 8'hFF, 23'h7FFFFF};
      end else if (ai || bi) begin
         exp_q.push_back(W_BUSY | W_SPLD | W_EPSET | W_MPHRST);
         p = {sg, 8'hFF, 23'h0};
      end else if (az || bz) begin
         exp_q.push_back(W_BUSY | W_SPLD | W_EPRST | W_MPHRST);
         p = {sg, 31'h0};
      end else begin
         exp_q.push_back(W_BUSY | W_SPLD | W_EPLD | W_MPHLD | W_MPLLD);
         exp_q.push_back(W_BUSY | W_EPLD | W_EP10);
         prod = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
         e = int'(a[30:23]) + int'(b[30:23]) - 127;
         if (prod[47]) begin
            exp_q.push_back(W_BUSY | W_EPLD | W_EP01);
            m = prod[47:24]; r = prod[23]; s = |prod[22:0]; e++;
         end else begin
            exp_q.push_back(W_BUSY | W_MPHLD | W_MPH001 | W_MPLLD | W_MPLSEL);
            m = prod[46:23]; r = prod[22]; s = |prod[21:0];
         end
         rnd = r & (m[0] | s);
         cy  = &m[22:0];
         if (rnd && cy) begin
            exp_q.push_back(W_BUSY | W_MPHLD | W_MPH100 | W_EPLD | W_EP01);
            m = 24'h800000; e++;
         end else if (rnd) begin
            exp_q.push_back(W_BUSY | W_MPHLD | W_MPH010);
            m = m + 24'd1;
         end else begin
            exp_q.push_back(W_BUSY);
         end
         if (e <= 0) begin
            exp_q.push_back(W_BUSY | W_UFLD | W_EPRST | W_MPHRST);
            p = {sg, 31'h0}; uf = 1'b1;
         end else if (e >= 255) begin
            exp_q.push_back(W_BUSY | W_OFLD | W_EPSET | W_MPHRST);
            p = {sg, 8'hFF, 23'h0}; of = 1'b1;
         end else begin
            exp_q.push_back(W_BUSY);
            p = {sg, e[7:0], m[22:0]};
         end
      end
      exp_q.push_back(W_BUSY | W_PLD);
      exp_q.push_back(W_BUSY | W_DONE);
   endtask

   // Per-cycle compare of the whole control word; idle cycles must be all zero.
   always @(negedge clk) begin
      logic [27:0] e;
      if (cmp_en) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 28'h0;
         check("ctrl_word", {4'h0, cw}, {4'h0, e});
         if (done) done_cnt++;
         if (MPH_LD && MPH_SEL == 3'b100 && EP_LD && EP_SEL == 2'b01) rc_seen = 1'b1;
      end
   end

   // ---------------- driver ----------------
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p_lit, input logic uf_lit, input logic of_lit,
                         input int lat_lit);
      logic [31:0] pm;
      logic        ufm, ofm;
      int          n;
      push_op(a, b, pm, ufm, ofm);
      check({nm, "_model_p"}, pm, p_lit);
      a_bus = a;
      b_bus = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_latency"}, n, lat_lit);
      @(posedge clk); #1;
      check({nm, "_p"}, p_q, p_lit);
      check({nm, "_uf"}, {31'h0, uf_q}, {31'h0, uf_lit});
      check({nm, "_of"}, {31'h0, of_q}, {31'h0, of_lit});
   endtask

   initial begin
      logic [31:0] pm;
      logic        ufm, ofm;
      int          n, first, d0;
      rst = 1'b1; start = 1'b0; a_bus = '0; b_bus = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_cw", {4'h0, cw}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      cmp_en = 1'b1;

      run_op("mul_2x4",     32'h40000000, 32'h40800000, 32'h41000000, 1'b0, 1'b0, 9);
      run_op("mul_15x15",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 9);
      rc_seen = 1'b0;
      run_op("round_carry", 32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 1'b0, 1'b0, 9);
      check("round_carry_same_cycle", {31'h0, rc_seen}, 32'h1);
      run_op("round_even",  32'h3FC00000, 32'h3F800001, 32'h3FC00002, 1'b0, 1'b0, 9);
      run_op("neg_sign",    32'hC0000000, 32'h40800000, 32'hC1000000, 1'b0, 1'b0, 9);
      run_op("nan_op",      32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 1'b0, 1'b0, 5);
      run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b0, 5);
      run_op("inf_x_two",   32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0, 5);
      run_op("zero_x_five", 32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 1'b0, 5);
      run_op("overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 1'b1, 9);
      run_op("underflow",   32'h00800000, 32'h00800000, 32'h00000000, 1'b1, 1'b0, 9);

      // rst in ROUND: back to IDLE with all outputs low on the next cycle
      push_op(32'h40000000, 32'h40800000, pm, ufm, ofm);
      a_bus = 32'h40000000; b_bus = 32'h40800000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      check("rst_mid_cw", {4'h0, cw}, 32'h0);
      check("rst_mid_busy", {31'h0, busy}, 32'h0);
      repeat (3) @(posedge clk);
      #1;

      // start pulsed in BIAS is ignored
      d0 = done_cnt;
      push_op(32'h3FC00000, 32'h3FC00000, pm, ufm, ofm);
      a_bus = 32'h3FC00000; b_bus = 32'h3FC00000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 5;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("bias_pulse_latency", n, 9);
      repeat (12) @(posedge clk);
      #1;
      check("bias_pulse_done_count", done_cnt - d0, 1);
      check("bias_pulse_p", p_q, 32'h40100000);

      // start held high: back-to-back operations
      push_op(32'h40000000, 32'h40800000, pm, ufm, ofm);
      push_op(32'h40000000, 32'h40800000, pm, ufm, ofm);
      a_bus = 32'h40000000; b_bus = 32'h40800000; start = 1'b1;
      n = 0;
      first = -1;
      while (n < 60) begin
         @(posedge clk); #1;
         n++;
         if (done) begin
            if (first < 0) first = n;
            else break;
         end
      end
      start = 1'b0;
      check("b2b_first_done", first, 9);
      check("b2b_second_done", n, 19);
      @(posedge clk); #1;
      check("b2b_p", p_q, 32'h41000000);
      repeat (4) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
